// File: rtl/fir_feed_ctrl.sv
// fir_feed_ctrl -- feeds mixer product samples into a FIR filter in framed
// bursts and registers the filter results.
//
// Sequence: IDLE -> DELAY (settle DELAY_CYC cycles) -> RUN (issue samples while
// source and filter are both ready) -> DRAIN (wait for all outstanding results)
// -> IDLE. A stop request only takes effect at a frame boundary. Loss of
// pll_lock aborts immediately.
//
// Ports:
//   sclk, s_rst            clock, synchronous active-high reset
//   pll_lock               clock-source lock; low aborts any active run
//   start, stop            single-cycle run / stop requests
//   src_valid, src_data    mixer product strobe and 19-bit value
//   fir_rfi_o              filter ready for input
//   fir_valid_o/fir_data_o filter result strobe and 31-bit value
//   fir_valid_i/fir_sync_i/fir_data_i  filter feed (sync marks sample 0)
//   out_valid, out_data    filter result delayed by one cycle
//   busy                   high whenever not IDLE
//   frame_done             pulses with the last sample of each frame
//   sign_led               toggles every LED_CNT output results
//   peak_mag               (only with FIR_FEED_PEAK_EN) largest |result| of the
//                          last completed result frame
//
// Optional feature macro: FIR_FEED_PEAK_EN adds the peak_mag port and logic.

module fir_feed_ctrl #(
  parameter int DELAY_CYC = 500,
  parameter int FRAME_LEN = 1024,
  parameter int LED_CNT   = 50000
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        pll_lock,
  input  logic        start,
  input  logic        stop,
  input  logic        src_valid,
  input  logic [18:0] src_data,
  input  logic        fir_rfi_o,
  input  logic        fir_valid_o,
  input  logic [30:0] fir_data_o,
  output logic        fir_valid_i,
  output logic        fir_sync_i,
  output logic [18:0] fir_data_i,
  output logic        out_valid,
  output logic [30:0] out_data,
  output logic        busy,
  output logic        frame_done,
  output logic        sign_led
`ifdef FIR_FEED_PEAK_EN
  ,
  output logic [30:0] peak_mag
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYC - 1);
  localparam logic [15:0] SMP_LAST = 16'(FRAME_LEN - 1);
  localparam logic [31:0] LED_LAST = 32'(LED_CNT - 1);

  state_e      state_q, state_d;
  logic [31:0] dly_cnt_q, dly_cnt_d;
  logic [15:0] smp_cnt_q, smp_cnt_d;
  logic [15:0] outst_q, outst_d;
  logic        stop_q, stop_d;
  logic        abort_s, issue_s, last_s;
  logic        busy_q, fir_valid_q, fir_sync_q, frame_done_q;
  logic [18:0] fir_data_q;
  logic        out_valid_q;
  logic [30:0] out_data_q;
  logic [31:0] led_cnt_q;
  logic        sign_led_q;

  assign last_s = (smp_cnt_q == SMP_LAST);

  // Next-state, delay/sample counters and stop latch
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    smp_cnt_d = smp_cnt_q;
    stop_d    = stop_q;
    abort_s   = 1'b0;
    issue_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && pll_lock) begin
          state_d   = DELAY;
          dly_cnt_d = 32'd0;
          smp_cnt_d = 16'd0;
          stop_d    = stop;      // start wins, a simultaneous stop is kept
        end else begin
          stop_d = 1'b0;
        end
      end
      DELAY: begin
        if (!pll_lock) begin
          abort_s = 1'b1;
        end else if (stop) begin
          state_d   = IDLE;
          dly_cnt_d = 32'd0;
          stop_d    = 1'b0;
        end else if (dly_cnt_q == DLY_LAST) begin
          state_d   = RUN;
          dly_cnt_d = 32'd0;
        end else begin
          dly_cnt_d = dly_cnt_q + 32'd1;
        end
      end
      RUN: begin
        if (!pll_lock) begin
          abort_s = 1'b1;
        end else begin
          stop_d = stop_q | stop;
          if (src_valid && fir_rfi_o) begin
            issue_s = 1'b1;
            if (last_s) begin
              smp_cnt_d = 16'd0;
              // Stop only honoured once a whole frame has gone out
              if (stop_q || stop) begin
                state_d = DRAIN;
                stop_d  = 1'b0;
              end else begin
                state_d = RUN;
              end
            end else begin
              smp_cnt_d = smp_cnt_q + 16'd1;
            end
          end else begin
            issue_s = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!pll_lock) begin
          abort_s = 1'b1;
        end else if ((outst_q == 16'd0) && !fir_valid_q) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_s) begin
      state_d   = IDLE;
      dly_cnt_d = 32'd0;
      smp_cnt_d = 16'd0;
      stop_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Outstanding-result count: +1 per fed sample, -1 per result, floor at zero
  always_comb begin
    outst_d = outst_q;
    if (abort_s) begin
      outst_d = 16'd0;
    end else if (fir_valid_q && !fir_valid_o) begin
      outst_d = outst_q + 16'd1;
    end else if (!fir_valid_q && fir_valid_o && (outst_q != 16'd0)) begin
      outst_d = outst_q - 16'd1;
    end else begin
      outst_d = outst_q;
    end
  end

  // Control state, counters and filter feed registers
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q      <= IDLE;
      dly_cnt_q    <= 32'd0;
      smp_cnt_q    <= 16'd0;
      outst_q      <= 16'd0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      fir_valid_q  <= 1'b0;
      fir_sync_q   <= 1'b0;
      fir_data_q   <= 19'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      outst_q      <= outst_d;
      stop_q       <= stop_d;
      busy_q       <= (state_d != IDLE);
      fir_valid_q  <= issue_s;
      fir_sync_q   <= issue_s && (smp_cnt_q == 16'd0);
      fir_data_q   <= issue_s ? src_data : 19'd0;
      frame_done_q <= issue_s && last_s;
    end
  end

  // Result path: one-cycle register plus LED toggle counter, active in all states
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 31'd0;
      led_cnt_q   <= 32'd0;
      sign_led_q  <= 1'b0;
    end else begin
      out_valid_q <= fir_valid_o;
      if (fir_valid_o) begin
        out_data_q <= fir_data_o;
      end
      if (out_valid_q) begin
        if (led_cnt_q == LED_LAST) begin
          led_cnt_q  <= 32'd0;
          sign_led_q <= ~sign_led_q;
        end else begin
          led_cnt_q <= led_cnt_q + 32'd1;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign fir_valid_i = fir_valid_q;
  assign fir_sync_i  = fir_sync_q;
  assign fir_data_i  = fir_data_q;
  assign frame_done  = frame_done_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign sign_led    = sign_led_q;

`ifdef FIR_FEED_PEAK_EN
  // Two's-complement magnitude; the most negative value cannot be negated
  function automatic logic [30:0] abs_sat(input logic [30:0] v);
    if (v[30]) begin
      if (v == 31'h4000_0000) begin
        return 31'h3FFF_FFFF;
      end else begin
        return (~v) + 31'd1;
      end
    end else begin
      return v;
    end
  endfunction

  logic [15:0] res_cnt_q;
  logic [30:0] peak_acc_q, peak_mag_q, mag_s, max_s;

  assign mag_s = abs_sat(fir_data_o);
  assign max_s = (mag_s > peak_acc_q) ? mag_s : peak_acc_q;

  // Per-frame peak over results; published and restarted at each frame end
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      res_cnt_q  <= 16'd0;
      peak_acc_q <= 31'd0;
      peak_mag_q <= 31'd0;
    end else if (fir_valid_o) begin
      if (res_cnt_q == SMP_LAST) begin
        res_cnt_q  <= 16'd0;
        peak_acc_q <= 31'd0;
        peak_mag_q <= max_s;
      end else begin
        res_cnt_q  <= res_cnt_q + 16'd1;
        peak_acc_q <= max_s;
      end
    end
  end

  assign peak_mag = peak_mag_q;
`endif

endmodule

// File: tb/tb_fir_feed_ctrl.sv
// Self-checking bench for fir_feed_ctrl (DELAY_CYC=8, FRAME_LEN=4, LED_CNT=2).
// A behavioural model predicts every output each cycle; directed sequences
// add hand-computed expectations, then randomized stimulus runs against the model.

module tb_fir_feed_ctrl;

  localparam int DLY = 8;
  localparam int FL  = 4;
  localparam int LC  = 2;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b0, pll_lock = 1'b0, start = 1'b0, stop = 1'b0;
  logic        src_valid = 1'b0, fir_rfi_o = 1'b0, fir_valid_o = 1'b0;
  logic [18:0] src_data = '0;
  logic [30:0] fir_data_o = '0;
  logic        fir_valid_i, fir_sync_i, out_valid, busy, frame_done, sign_led;
  logic [18:0] fir_data_i;
  logic [30:0] out_data;
`ifdef FIR_FEED_PEAK_EN
  logic [30:0] peak_mag;
`endif

  fir_feed_ctrl #(.DELAY_CYC(DLY), .FRAME_LEN(FL), .LED_CNT(LC)) dut (
    .sclk(sclk), .s_rst(s_rst), .pll_lock(pll_lock), .start(start), .stop(stop),
    .src_valid(src_valid), .src_data(src_data), .fir_rfi_o(fir_rfi_o),
    .fir_valid_o(fir_valid_o), .fir_data_o(fir_data_o),
    .fir_valid_i(fir_valid_i), .fir_sync_i(fir_sync_i), .fir_data_i(fir_data_i),
    .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .frame_done(frame_done), .sign_led(sign_led)
`ifdef FIR_FEED_PEAK_EN
    , .peak_mag(peak_mag)
`endif
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;

  // Behavioural model: run phase as flags/countdown, samples as a running count
  bit          m_valid = 0;
  bit          m_active, m_drain, m_stop;
  int          m_settle, m_cnt, m_outst, led_seen;
  bit          e_fv, e_fs, e_done, e_ov;
  logic [18:0] e_fd;
  logic [30:0] e_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (m_valid) begin
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("fir_valid_i", {31'd0, fir_valid_i}, {31'd0, e_fv});
      chk("fir_sync_i", {31'd0, fir_sync_i}, {31'd0, e_fs});
      chk("fir_data_i", {13'd0, fir_data_i}, {13'd0, e_fd});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      chk("out_data", {1'b0, out_data}, {1'b0, e_od});
      chk("sign_led", {31'd0, sign_led}, 32'((led_seen / LC) % 2));
    end
  endtask

  task automatic model_step(input bit rst, st, sp, lk, sv, input logic [18:0] sd,
                            input bit rfi, fov, input logic [30:0] fod);
    bit issue;
    int pos, n_outst;
    if (rst) begin
      m_valid = 1; m_active = 0; m_drain = 0; m_stop = 0; m_settle = 0; m_cnt = 0;
      m_outst = 0; led_seen = 0;
      e_fv = 0; e_fs = 0; e_done = 0; e_ov = 0; e_fd = '0; e_od = '0;
      return;
    end
    if (e_ov) led_seen++;
    e_ov = fov;
    if (fov) e_od = fod;
    n_outst = m_outst + int'(e_fv) - int'(fov);
    if (n_outst < 0) n_outst = 0;
    issue = 0;
    pos = 0;
    if (!m_active) begin
      if (st && lk) begin
        m_active = 1; m_settle = DLY; m_drain = 0; m_cnt = 0; m_stop = sp;
      end
    end else if (!lk) begin
      m_active = 0; m_settle = 0; m_drain = 0; m_cnt = 0; m_stop = 0; n_outst = 0;
    end else if (m_settle > 0) begin
      if (sp) begin
        m_active = 0; m_settle = 0; m_stop = 0;
      end else begin
        m_settle--;
      end
    end else if (!m_drain) begin
      m_stop = m_stop | sp;
      if (sv && rfi) begin
        issue = 1;
        pos = m_cnt % FL;
        m_cnt++;
        if (pos == FL - 1 && m_stop) begin
          m_drain = 1; m_stop = 0;
        end
      end
    end else if (m_outst == 0 && !e_fv) begin
      m_active = 0; m_drain = 0;
    end
    e_fv = issue;
    e_fs = issue && (pos == 0);
    e_done = issue && (pos == FL - 1);
    e_fd = issue ? sd : 19'd0;
    m_outst = n_outst;
  endtask

  // One clock: check last cycle's outputs, drive new inputs, advance model
  task automatic tick(input bit rst, st, sp, lk, sv, input logic [18:0] sd,
                      input bit rfi, fov, input logic [30:0] fod);
    @(negedge sclk);
    compare_model();
    s_rst = rst; start = st; stop = sp; pll_lock = lk; src_valid = sv;
    src_data = sd; fir_rfi_o = rfi; fir_valid_o = fov; fir_data_o = fod;
    model_step(rst, st, sp, lk, sv, sd, rfi, fov, fod);
  endtask

  task automatic after_edge();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 1, 0, 19'd0, 0, 0, 31'd0);
  endtask

  initial begin
    int first, n, cnt_iss, toggles, busy_gone;
    logic led_prev;
    logic [30:0] rv [4];
    rv[0] = 31'd5; rv[1] = 31'h7FFF_FFF7; rv[2] = 31'd3; rv[3] = 31'd7;

    // Reset state
    repeat (3) tick(1, 0, 0, 1, 0, 19'd0, 0, 0, 31'd0);
    after_edge();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fir_valid_i", {31'd0, fir_valid_i}, 32'd0);
    chk("rst_fir_data_i", {13'd0, fir_data_i}, 32'd0);
    chk("rst_out_data", {1'b0, out_data}, 32'd0);
    chk("rst_sign_led", {31'd0, sign_led}, 32'd0);

    // Start, settle, then continuous feed with src_data = sample number
    tick(0, 1, 0, 1, 0, 19'd0, 0, 0, 31'd0);
    after_edge();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    first = -1;
    for (int k = 1; k <= 21; k++) begin
      tick(0, 0, 0, 1, 1, 19'(k - 9), 1, 0, 31'd0);
      after_edge();
      if (fir_valid_i === 1'b1 && first < 0) first = k;
      if (k >= 9 && k <= 17) begin
        n = k - 9;
        chk("ramp_data", {13'd0, fir_data_i}, 32'(n));
        chk("ramp_sync", {31'd0, fir_sync_i}, 32'(n % 4 == 0));
        chk("ramp_done", {31'd0, frame_done}, 32'(n % 4 == 3));
      end
    end
    chk("first_valid_latency", first, 32'd9);

    // Lock loss mid-frame aborts at once
    tick(0, 0, 0, 0, 1, 19'd77, 1, 0, 31'd0);
    after_edge();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, fir_valid_i}, 32'd0);

    // Restart; stop during sample 1 lets exactly one frame out
    tick(0, 1, 0, 1, 0, 19'd0, 0, 0, 31'd0);
    cnt_iss = 0;
    for (int k = 1; k <= 24; k++) begin
      tick(0, 0, (k == 10), 1, 1, 19'(k), 1, 0, 31'd0);
      after_edge();
      if (fir_valid_i === 1'b1) begin
        if (cnt_iss == 0) chk("restart_sync", {31'd0, fir_sync_i}, 32'd1);
        cnt_iss++;
      end
    end
    chk("stop_sample_count", cnt_iss, 32'd4);

    // Return the four results; LED toggles twice
    led_prev = sign_led;
    toggles = 0;
    for (int p = 0; p < 4; p++) begin
      tick(0, 0, 0, 1, 0, 19'd0, 0, 1, rv[p]);
      after_edge();
      if (sign_led !== led_prev) toggles++;
      led_prev = sign_led;
      if (p == 2) chk("busy_3_returned", {31'd0, busy}, 32'd1);
      if (p < 3) begin
        idle_tick();
        after_edge();
        if (sign_led !== led_prev) toggles++;
        led_prev = sign_led;
      end
    end
    busy_gone = 0;
    for (int w = 0; w < 2; w++) begin
      idle_tick();
      after_edge();
      if (sign_led !== led_prev) toggles++;
      led_prev = sign_led;
      if (busy === 1'b0 && busy_gone == 0) busy_gone = 1;
    end
    chk("busy_drop_within_2", busy_gone, 32'd1);
    for (int w = 0; w < 3; w++) begin
      idle_tick();
      after_edge();
      if (sign_led !== led_prev) toggles++;
      led_prev = sign_led;
    end
    chk("led_toggles", toggles, 32'd2);
    chk("led_final", {31'd0, sign_led}, 32'd0);
    chk("out_data_last", {1'b0, out_data}, 32'd7);
`ifdef FIR_FEED_PEAK_EN
    chk("peak_mag", {1'b0, peak_mag}, 32'd9);
`endif

    // Filter ready only on alternate cycles
    tick(0, 1, 0, 1, 0, 19'd0, 0, 0, 31'd0);
    for (int k = 1; k <= 30; k++) begin
      tick(0, 0, 0, 1, 1, 19'(100 + k), k[0], 0, 31'd0);
      after_edge();
      if (k >= 9) chk("alt_issue", {31'd0, fir_valid_i}, 32'(k[0]));
      if (fir_valid_i !== 1'b1) chk("alt_gap_data", {13'd0, fir_data_i}, 32'd0);
    end

    // Randomized traffic checked against the model
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 79) != 0),
           ($urandom_range(0, 3) != 0), 19'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), 31'($urandom));
    end
    idle_tick();
    idle_tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_feed_ctrl.md
FIR_FEED_CTRL -- requirements
Module: fir_feed_ctrl

Interface
REQ-001 SHALL have parameter DELAY_CYC, default 500: start-up settle cycles after start before feeding.
REQ-002 SHALL have parameter FRAME_LEN, default 1024: samples per frame; range 2..65535.
REQ-003 SHALL have parameter LED_CNT, default 50000: output samples per sign_led toggle.
REQ-004 SHALL have port sclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port s_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pll_lock, input, 1: clock-source lock; low forces abort.
REQ-007 SHALL have ports start and stop, input, 1 each: single-cycle run and stop requests.
REQ-008 SHALL have ports src_valid (input, 1) and src_data (input, 19): mixer product sample strobe and value.
REQ-009 SHALL have ports fir_rfi_o (input, 1), fir_valid_o (input, 1) and fir_data_o (input, 31): filter ready, result strobe and result.
REQ-010 SHALL have ports fir_valid_i (output, 1), fir_sync_i (output, 1) and fir_data_i (output, 19): filter feed.
REQ-011 SHALL have ports out_valid (output, 1) and out_data (output, 31): registered filter result.
REQ-012 SHALL have ports busy (output, 1), frame_done (output, 1) and sign_led (output, 1).

Function
REQ-013 SHALL implement states IDLE, DELAY, RUN and DRAIN; busy = (state != IDLE).
REQ-014 IDLE -> DELAY SHALL occur when start=1 and pll_lock=1; the delay counter loads 0.
REQ-015 DELAY SHALL count one per cycle and go to RUN on the cycle the count reaches DELAY_CYC-1; stop in DELAY -> IDLE.
REQ-016 In RUN, a sample SHALL be issued when src_valid=1 and fir_rfi_o=1: next cycle fir_valid_i=1, fir_data_i=src_data (1-cycle latency).
REQ-017 fir_data_i SHALL be 0 whenever fir_valid_i=0.
REQ-018 fir_sync_i SHALL be 1 together with fir_valid_i only for sample index 0 of each frame.
REQ-019 A sample counter SHALL wrap from FRAME_LEN-1 to 0; frame_done SHALL pulse 1 cycle, concurrent with fir_valid_i of the last sample.
REQ-020 stop seen in RUN SHALL be latched; at the next frame end, RUN -> DRAIN and no further samples issue (frames are never truncated).
REQ-021 An outstanding counter (16 bit) SHALL +1 per fir_valid_i, -1 per fir_valid_o, and be unchanged when both occur in the same cycle; it saturates at 0.
REQ-022 DRAIN -> IDLE SHALL occur when outstanding = 0 and fir_valid_i = 0.
REQ-023 start while busy SHALL be ignored; start and stop in the same IDLE cycle: start wins, stop latched.
REQ-024 pll_lock=0 in any non-IDLE state SHALL force IDLE next cycle, clearing all counters, the stop latch, fir_valid_i and fir_sync_i.
REQ-025 out_valid/out_data SHALL register fir_valid_o/fir_data_o with 1-cycle latency, in every state; out_data holds between strobes.
REQ-026 sign_led SHALL toggle after every LED_CNT out_valid pulses (counter wraps at LED_CNT-1).

Reset
REQ-027 With s_rst=1 at an edge: state=IDLE, all counters=0, stop latch=0, fir_valid_i=fir_sync_i=0, fir_data_i=0, out_valid=0, out_data=0, frame_done=0, busy=0, sign_led=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-frame; no partial frame resumes after release.

Configuration
REQ-029 Macro FIR_FEED_PEAK_EN SHALL, when defined, add output peak_mag (31 bit): the largest |fir_data_o| (two's complement) of the current frame, updated at frame end. Increment on fir_valid_o; reset to 0. Absolute value of the most negative value saturates to 2^30-1.
REQ-030 Without FIR_FEED_PEAK_EN, the peak_mag port and its logic SHALL be absent; all other behaviour is identical.

Verification (DELAY_CYC=8, FRAME_LEN=4, LED_CNT=2 unless stated)
REQ-031 Apply s_rst, then start with pll_lock=1 -> busy=1 next cycle; first fir_valid_i no earlier than 9 cycles after start.
REQ-032 src_valid=fir_rfi_o=1 continuously, src_data=n -> fir_data_i=0,1,2,... on consecutive cycles; fir_sync_i at samples 0,4,8; frame_done at samples 3,7.
REQ-033 fir_rfi_o low on alternate cycles -> fir_valid_i only follows cycles where fir_rfi_o=1; fir_data_i=0 in the gaps.
REQ-034 stop at sample 1 -> exactly 4 samples issued; with 3 fir_valid_o returned busy=1, and after the 4th busy=0 within 2 cycles.
REQ-035 pll_lock dropped mid-frame -> IDLE next cycle, fir_valid_i=0; a restart begins with fir_sync_i on sample 0.
REQ-036 Four fir_valid_o pulses -> sign_led toggles twice; with FIR_FEED_PEAK_EN, fir_data_o=5,-9,3,7 -> peak_mag=9.
